// File: rtl/led_cube_uart_pkg.sv
// Shared definitions for the cube's UART Avalon masters: register map,
// status bit positions and the transmit FSM state type.
package led_cube_uart_pkg;

    localparam int unsigned UART_REG_RXDATA  = 0;
    localparam int unsigned UART_REG_TXDATA  = 1;
    localparam int unsigned UART_REG_STATUS  = 2;
    localparam int unsigned UART_REG_CONTROL = 3;

    localparam int unsigned UART_ST_TMT  = 5;
    localparam int unsigned UART_ST_TRDY = 6;
    localparam int unsigned UART_ST_RRDY = 7;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_STAT_RD,
        TX_STAT_WAIT,
        TX_GAP,
        TX_WRITE
    } tx_state_e;

endpackage

// File: rtl/led_cube_byte_fifo.sv
// Byte FIFO buffering outgoing characters; can_push is registered from the
// next-cycle count so it never lets a push land on a full buffer.
module led_cube_byte_fifo #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    output logic [7:0]               head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     can_push
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          can_push_q, can_push_d;
    logic          push_ok, pop_ok;

    assign full     = (count_q == DEPTH_C);
    assign empty    = (count_q == '0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign head     = mem_q[rd_ptr_q];
    assign count    = count_q;
    assign can_push = can_push_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        can_push_d = (count_d < DEPTH_C);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            can_push_q <= 1'b1;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            can_push_q <= can_push_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/led_cube_uart_tx.sv
// Transmit-side Avalon-MM master: buffers bytes, polls UART status until TRDY,
// then writes one byte to txdata per successful status read.
module led_cube_uart_tx
    import led_cube_uart_pkg::*;
#(
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned ADDR_TXDATA = UART_REG_TXDATA,
    parameter int unsigned ADDR_STATUS = UART_REG_STATUS,
    parameter int unsigned TRDY_BIT    = UART_ST_TRDY,
    parameter int unsigned POLL_GAP    = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [7:0]               tx_data,
    input  logic                     tx_valid,
    output logic                     tx_ready,
    output logic [4:0]               avm_address,
    output logic                     avm_read,
    input  logic [15:0]              avm_readdata,
    input  logic                     avm_readdatavalid,
    input  logic                     avm_waitrequest,
    output logic                     avm_write,
    output logic [15:0]              avm_writedata,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     tx_busy
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned GW = $clog2(POLL_GAP + 1);
    localparam logic [4:0]    ADDR_TX_C = 5'(ADDR_TXDATA);
    localparam logic [4:0]    ADDR_ST_C = 5'(ADDR_STATUS);
    localparam logic [GW-1:0] GAP_LOAD  = GW'(POLL_GAP);

    tx_state_e     state_q, state_d;
    logic [GW-1:0] poll_q, poll_d;

    logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0]    fifo_head;
    logic          trdy;
    logic          rdata_unused;

    assign trdy         = avm_readdata[TRDY_BIT];
    assign rdata_unused = ^avm_readdata;
    assign fifo_push    = tx_valid && tx_ready && !fifo_full;
    assign tx_busy      = !fifo_empty || (state_q != TX_IDLE);

    led_cube_byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (tx_data),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .can_push  (tx_ready)
    );

    always_comb begin
        state_d       = state_q;
        poll_d        = poll_q;
        avm_read      = 1'b0;
        avm_write     = 1'b0;
        avm_address   = ADDR_ST_C;
        avm_writedata = '0;
        fifo_pop      = 1'b0;
        case (state_q)
            TX_IDLE: begin
                // Watching the push as well as the count saves a cycle of latency.
                if (!fifo_empty || fifo_push) state_d = TX_STAT_RD;
            end
            TX_STAT_RD: begin
                avm_read = 1'b1;
                if (!avm_waitrequest) begin
                    if (avm_readdatavalid) begin
                        if (trdy) begin
                            state_d = TX_WRITE;
                        end else begin
                            state_d = TX_GAP;
                            poll_d  = GAP_LOAD;
                        end
                    end else begin
                        state_d = TX_STAT_WAIT;
                    end
                end
            end
            TX_STAT_WAIT: begin
                if (avm_readdatavalid) begin
                    if (trdy) begin
                        state_d = TX_WRITE;
                    end else begin
                        state_d = TX_GAP;
                        poll_d  = GAP_LOAD;
                    end
                end
            end
            TX_GAP: begin
                poll_d = poll_q - 1'b1;
                if (poll_q <= GW'(1)) state_d = TX_STAT_RD;
            end
            TX_WRITE: begin
                avm_write     = 1'b1;
                avm_address   = ADDR_TX_C;
                avm_writedata = {8'h00, fifo_head};
                if (!avm_waitrequest) begin
                    fifo_pop = 1'b1;
                    // A same-cycle push keeps the FIFO non-empty after this pop.
                    if (fifo_count == CW'(1) && !fifo_push) state_d = TX_IDLE;
                    else                                     state_d = TX_STAT_RD;
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= TX_IDLE;
            poll_q  <= '0;
        end else begin
            state_q <= state_d;
            poll_q  <= poll_d;
        end
    end

endmodule
